mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: AW, 32, address width in bits.
REQ-002 Parameter: DW, 32, data width in bits.
REQ-003 Parameter: MAX_D, 2, maximum consecutive data grants while a fetch request is pending.
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous and active-high.
REQ-006 Port: if_req  in  1  fetch request; held until if_valid is seen.
REQ-007 Port: if_addr  in  AW  fetch address.
REQ-008 Port: if_rdata  out  DW  fetched instruction, registered.
REQ-009 Port: if_valid  out  1  one-cycle completion pulse for a fetch.
REQ-010 Port: dm_req  in  1  data-stage request; held until dm_valid is seen.
REQ-011 Port: dm_we  in  1  1 = store, 0 = load.
REQ-012 Port: dm_addr  in  AW  data address.
REQ-013 Port: dm_wdata  in  DW  store data.
REQ-014 Port: dm_rdata  out  DW  load data, registered.
REQ-015 Port: dm_valid  out  1  one-cycle completion pulse for a data access.
REQ-016 Port: mem_req  out  1  request to the shared memory.
REQ-017 Port: mem_we  out  1  write enable to memory.
REQ-018 Port: mem_addr  out  AW  memory address.
REQ-019 Port: mem_wdata  out  DW  memory write data.
REQ-020 Port: mem_rdata  in  DW  memory read data; valid while mem_ack=1.
REQ-021 Port: mem_ack  in  1  memory completion; any latency of 0 or more cycles after mem_req rises.
REQ-022 Port: stall_if  out  1  fetch-stage stall = if_req & ~if_valid (combinational).
REQ-023 Port: stall_mem  out  1  memory-stage stall = dm_req & ~dm_valid (combinational).

Function
REQ-024 The FSM SHALL use states IDLE, SERVE_D, SERVE_I and DONE.
REQ-025 IDLE, both requests low: remain in IDLE.
REQ-026 IDLE, one request high: grant that request (data -> SERVE_D, fetch -> SERVE_I).
REQ-027 IDLE, both requests high: grant data unless d_cnt == MAX_D, in which case grant fetch.
REQ-028 At grant: latch addr, we and wdata into internal registers; mem_addr, mem_we and mem_wdata come from these registers only.
REQ-029 SERVE_D and SERVE_I: mem_req = 1; mem_we = latched we in SERVE_D and 0 in SERVE_I; state held until mem_ack = 1.
REQ-030 mem_ack = 1 in a SERVE state: capture mem_rdata into dm_rdata (loads only) or if_rdata, then go to DONE.
REQ-031 Stores: dm_rdata is left unchanged.
REQ-032 DONE: pulse the matching valid for exactly one cycle, mem_req = 0, then go to IDLE unconditionally.
REQ-033 Minimum access time with zero-wait memory: grant edge, ack cycle, DONE cycle, i.e. valid appears 2 cycles after the grant edge; the next grant is no earlier than the following IDLE cycle.
REQ-034 d_cnt is a saturating counter of width clog2(MAX_D+1).
REQ-035 d_cnt increments on a data grant made while if_req = 1.
REQ-036 d_cnt clears on any fetch grant, and on a data grant made while if_req = 0.
REQ-037 mem_ack in IDLE or DONE SHALL be ignored with no state change.
REQ-038 Requester inputs that change after grant SHALL NOT affect the transaction in flight.
REQ-039 At most one of if_valid and dm_valid SHALL be high in any cycle.
REQ-040 mem_req SHALL be 0 in IDLE and DONE.

Reset
REQ-041 While rst = 1: state = IDLE, d_cnt = 0, mem_req = 0, mem_we = 0, if_valid = 0, dm_valid = 0; mem_addr, mem_wdata, if_rdata and dm_rdata = 0.
REQ-042 Reset asserted mid-transaction SHALL abandon the transaction with no valid pulse; after reset, requests still held high are re-arbitrated from IDLE.

Verification
REQ-043 Fetch only, if_addr=0x40, mem_ack on the first SERVE cycle with mem_rdata=0x00500093 -> if_rdata=0x00500093 and if_valid pulses 2 cycles after grant; stall_if high until that pulse.
REQ-044 Both requests raised together, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF -> store served first with mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; fetch served next.
REQ-045 Fairness: dm_req and if_req held high continuously, new data request after each dm_valid -> grant order D, D, I, D, D, I.
REQ-046 Load with mem_ack delayed 5 cycles -> mem_req held 6 cycles, mem_addr stable, dm_valid pulses once, stall_mem high throughout.
REQ-047 rst pulsed in SERVE_I before ack -> mem_req=0 and no if_valid; after release with if_req still high, fetch re-granted from IDLE.
REQ-048 Spurious mem_ack in IDLE with no requests -> no valid pulse, outputs unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one memory port between instruction fetch and the
// data stage. Data requests normally win, but after MAX_D consecutive data
// grants made while a fetch is waiting, the fetch is served next.
// Every access follows the same path: grant, serve until ack, one-cycle done.
module mem_port_arbiter #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int MAX_D = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall_if,
  output logic          stall_mem
);

  // Counter wide enough to hold MAX_D; never narrower than one bit.
  localparam int CW = (MAX_D < 1) ? 1 : $clog2(MAX_D + 1);
  localparam logic [CW-1:0] D_LIMIT = CW'(MAX_D);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_D = 2'd1,
    SERVE_I = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] d_cnt_reg, d_cnt_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic          we_reg, we_next;
  logic [DW-1:0] wdata_reg, wdata_next;
  logic          gnt_d_reg, gnt_d_next;    // last grant went to the data stage
  logic [DW-1:0] if_rdata_reg, if_rdata_next;
  logic [DW-1:0] dm_rdata_reg, dm_rdata_next;

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      d_cnt_reg    <= '0;
      addr_reg     <= '0;
      we_reg       <= 1'b0;
      wdata_reg    <= '0;
      gnt_d_reg    <= 1'b0;
      if_rdata_reg <= '0;
      dm_rdata_reg <= '0;
    end else begin
      state_reg    <= state_next;
      d_cnt_reg    <= d_cnt_next;
      addr_reg     <= addr_next;
      we_reg       <= we_next;
      wdata_reg    <= wdata_next;
      gnt_d_reg    <= gnt_d_next;
      if_rdata_reg <= if_rdata_next;
      dm_rdata_reg <= dm_rdata_next;
    end
  end

  // Arbitration, grant-time latching and read-data capture.
  always_comb begin
    state_next    = state_reg;
    d_cnt_next    = d_cnt_reg;
    addr_next     = addr_reg;
    we_next       = we_reg;
    wdata_next    = wdata_reg;
    gnt_d_next    = gnt_d_reg;
    if_rdata_next = if_rdata_reg;
    dm_rdata_next = dm_rdata_reg;
    case (state_reg)
      IDLE: begin
        // Data wins unless it has already taken its quota ahead of a waiting fetch.
        if (dm_req && (!if_req || (d_cnt_reg != D_LIMIT))) begin
          state_next = SERVE_D;
          gnt_d_next = 1'b1;
          addr_next  = dm_addr;
          we_next    = dm_we;
          wdata_next = dm_wdata;
          if (!if_req) begin
            d_cnt_next = '0;
          end else if (d_cnt_reg != D_LIMIT) begin
            d_cnt_next = d_cnt_reg + CW'(1);
          end
        end else if (if_req) begin
          state_next = SERVE_I;
          gnt_d_next = 1'b0;
          addr_next  = if_addr;
          we_next    = 1'b0;
          d_cnt_next = '0;
        end
      end
      SERVE_D: begin
        if (mem_ack) begin
          // Stores leave the load-data register untouched.
          if (!we_reg) begin
            dm_rdata_next = mem_rdata;
          end
          state_next = DONE;
        end
      end
      SERVE_I: begin
        if (mem_ack) begin
          if_rdata_next = mem_rdata;
          state_next    = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Memory side is driven only from latched values so requesters may move on after grant.
  assign mem_req   = (state_reg == SERVE_D) || (state_reg == SERVE_I);
  assign mem_we    = (state_reg == SERVE_D) && we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

  assign if_rdata  = if_rdata_reg;
  assign dm_rdata  = dm_rdata_reg;
  assign if_valid  = (state_reg == DONE) && !gnt_d_reg;
  assign dm_valid  = (state_reg == DONE) && gnt_d_reg;

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grants and
// completions, a negedge monitor pops and compares them as the DUT shows them.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_if;
  logic        stall_mem;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_wdata;
  } grant_t;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    int          lat;
  } cpl_t;

  grant_t gq[$];
  cpl_t   cq[$];

  // Memory model controls
  int          ack_lat  = 0;
  logic [31:0] rdata_val = 32'h0;
  logic        spur_ack = 1'b0;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_D(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: ack after ack_lat waiting cycles of mem_req, one-cycle pulse.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      tick();
      mem_ack = 1'b0;
      if (mem_req) begin
        if (wait_cnt == ack_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata_val;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        if (spur_ack) begin
          mem_ack   = 1'b1;
          mem_rdata = 32'h9999_9999;
        end
      end
    end
  end

  // Monitor: compares grants on mem_req rise and completions on valid pulses.
  initial begin
    int     cyc;
    int     rise_cyc;
    int     serve_cnt;
    logic   req_prev;
    grant_t g;
    cpl_t   c;
    cyc       = 0;
    rise_cyc  = 0;
    serve_cnt = 0;
    req_prev  = 1'b0;
    g = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, chk_wdata: 1'b0};
    forever begin
      @(negedge clk);
      cyc++;
      chk("stall_if", 32'(stall_if), 32'(if_req & ~if_valid));
      chk("stall_mem", 32'(stall_mem), 32'(dm_req & ~dm_valid));
      chk("valid_onehot", 32'(if_valid & dm_valid), 32'h0);
      if (mem_req && !req_prev) begin
        rise_cyc  = cyc;
        serve_cnt = 0;
        if (gq.size() == 0) begin
          chk("grant_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          g = gq.pop_front();
          if (g.chk_wdata) chk("grant_wdata", mem_wdata, g.wdata);
          $display("grant: addr=%h we=%0d wdata=%h", mem_addr, mem_we, mem_wdata);
        end
      end
      if (mem_req) begin
        serve_cnt++;
        chk("mem_addr", mem_addr, g.addr);
        chk("mem_we", 32'(mem_we), 32'(g.we));
      end
      req_prev = mem_req;
      if (if_valid || dm_valid) begin
        if (cq.size() == 0) begin
          chk("valid_unexpected", 32'({if_valid, dm_valid}), 32'h0);
        end else begin
          c = cq.pop_front();
          chk("valid_kind", 32'(dm_valid), 32'(c.is_d));
          if (c.is_d) chk("dm_rdata", dm_rdata, c.rdata);
          else        chk("if_rdata", if_rdata, c.rdata);
          chk("latency", 32'(cyc - rise_cyc), 32'(c.lat + 1));
          chk("serve_cycles", 32'(serve_cnt), 32'(c.lat + 1));
          $display("done: %s rdata=%h latency=%0d", c.is_d ? "data" : "fetch",
                   c.is_d ? dm_rdata : if_rdata, cyc - rise_cyc);
        end
      end
    end
  end

  task automatic push_grant(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic cw);
    gq.push_back('{we: we, addr: addr, wdata: wdata, chk_wdata: cw});
  endtask

  task automatic push_cpl(input logic is_d, input logic [31:0] rdata, input int lat);
    cq.push_back('{is_d: is_d, rdata: rdata, lat: lat});
  endtask

  // Hold requests until the given number of completions of each kind is seen.
  task automatic wait_valids(input int n_d, input int n_i, input int budget);
    int seen_d;
    int seen_i;
    int t;
    seen_d = 0;
    seen_i = 0;
    t = 0;
    while ((seen_d < n_d || seen_i < n_i) && t < budget) begin
      tick();
      t++;
      if (dm_valid) begin
        seen_d++;
        if (seen_d >= n_d) dm_req = 1'b0;
      end
      if (if_valid) begin
        seen_i++;
        if (seen_i >= n_i) if_req = 1'b0;
      end
    end
    if (seen_d < n_d || seen_i < n_i) begin
      chk("wait_timeout", 32'(seen_d * 16 + seen_i), 32'(n_d * 16 + n_i));
      dm_req = 1'b0;
      if_req = 1'b0;
    end
  endtask

  initial begin
    int t;
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    chk("rst_valids", 32'({if_valid, dm_valid}), 32'h0);
    rst = 1'b0;
    tick();

    // Fetch only, zero-wait memory
    ack_lat = 0; rdata_val = 32'h0050_0093;
    push_grant(1'b0, 32'h40, 32'h0, 1'b0);
    push_cpl(1'b0, 32'h0050_0093, 0);
    if_addr = 32'h40; if_req = 1'b1;
    wait_valids(0, 1, 50);
    tick();

    // Store and fetch raised together: store first, then fetch
    rdata_val = 32'h1111_1111;
    push_grant(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1);
    push_cpl(1'b1, 32'h0, 0);
    push_grant(1'b0, 32'h44, 32'h0, 1'b0);
    push_cpl(1'b0, 32'h1111_1111, 0);
    dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_req = 1'b1;
    if_addr = 32'h44; if_req = 1'b1;
    wait_valids(1, 1, 50);
    tick();

    // Load with 5 wait cycles; inputs scrambled after the grant
    ack_lat = 5; rdata_val = 32'hCAFE_F00D;
    push_grant(1'b0, 32'h200, 32'h0, 1'b0);
    push_cpl(1'b1, 32'hCAFE_F00D, 5);
    dm_we = 1'b0; dm_addr = 32'h200; dm_req = 1'b1;
    tick(); tick();
    dm_addr = 32'hFFF0; dm_we = 1'b1; dm_wdata = 32'h1234_5678;
    wait_valids(1, 0, 50);
    tick();

    // Fairness: both held high, order D D I D D I
    ack_lat = 0; rdata_val = 32'h2222_2222;
    dm_we = 1'b0; dm_addr = 32'h300; if_addr = 32'h48;
    push_grant(1'b0, 32'h300, 32'h0, 1'b0); push_cpl(1'b1, 32'h2222_2222, 0);
    push_grant(1'b0, 32'h300, 32'h0, 1'b0); push_cpl(1'b1, 32'h2222_2222, 0);
    push_grant(1'b0, 32'h48,  32'h0, 1'b0); push_cpl(1'b0, 32'h2222_2222, 0);
    push_grant(1'b0, 32'h300, 32'h0, 1'b0); push_cpl(1'b1, 32'h2222_2222, 0);
    push_grant(1'b0, 32'h300, 32'h0, 1'b0); push_cpl(1'b1, 32'h2222_2222, 0);
    push_grant(1'b0, 32'h48,  32'h0, 1'b0); push_cpl(1'b0, 32'h2222_2222, 0);
    dm_req = 1'b1; if_req = 1'b1;
    wait_valids(4, 2, 200);
    tick(); tick();

    // Spurious ack while idle
    spur_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("spur_mem_req", 32'(mem_req), 32'h0);
      chk("spur_valids", 32'({if_valid, dm_valid}), 32'h0);
    end
    spur_ack = 1'b0;
    tick(); tick();
    chk("spur_if_rdata", if_rdata, 32'h2222_2222);
    chk("spur_dm_rdata", dm_rdata, 32'h2222_2222);
    chk("spur_mem_addr", mem_addr, 32'h48);
    $display("spurious ack: if_rdata=%h dm_rdata=%h", if_rdata, dm_rdata);

    // Reset during a fetch, then re-arbitration from idle
    ack_lat = 20;
    push_grant(1'b0, 32'h80, 32'h0, 1'b0);
    if_addr = 32'h80; if_req = 1'b1;
    t = 0;
    while (!mem_req && t < 20) begin
      tick();
      t++;
    end
    chk("abort_serving", 32'(mem_req), 32'h1);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("abort_mem_req", 32'(mem_req), 32'h0);
    chk("abort_if_valid", 32'(if_valid), 32'h0);
    chk("abort_if_rdata", if_rdata, 32'h0);
    chk("abort_mem_addr", mem_addr, 32'h0);
    tick(); tick();
    ack_lat = 0; rdata_val = 32'h3333_3333;
    push_grant(1'b0, 32'h80, 32'h0, 1'b0);
    push_cpl(1'b0, 32'h3333_3333, 0);
    rst = 1'b0;
    $display("reset abort: re-arbitrating fetch");
    wait_valids(0, 1, 50);
    tick(); tick(); tick();

    chk("grant_queue_empty", 32'(gq.size()), 32'h0);
    chk("cpl_queue_empty", 32'(cq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
